uart_tx_arbiter: RTL and testbench

//   Shares one UART_driver transmitter among NUM_REQ byte producers. Round-robin

---
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Supports multi-byte message locking, start-handshake timeout and lock-idle timeout.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned START_TIMEOUT = 8,
    parameter int unsigned LOCK_TIMEOUT  = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           uart_start,
    output logic [DATA_BITS-1:0]           uart_data,
    input  logic                           uart_ready,
    input  logic                           uart_busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           locked,
    output logic                           err_timeout
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned TMax = (START_TIMEOUT > LOCK_TIMEOUT) ? START_TIMEOUT : LOCK_TIMEOUT;
    localparam int unsigned CntW = $clog2(TMax + 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StWaitBusy, StWaitDone} state_e;

    state_e               state_q, state_d;
    logic [IdW-1:0]       grant_q, grant_d;
    logic [IdW-1:0]       rr_q, rr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 last_q, last_d;
    logic                 locked_q, locked_d;
    logic                 err_q, err_d;
    logic [CntW-1:0]      timer_q, timer_d;
    logic                 found;
    logic [IdW-1:0]       winner;

    function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
        return (id == IdW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    function automatic logic [IdW-1:0] rr_index(input logic [IdW-1:0] base, input int unsigned off);
        return IdW'((32'(base) + off) % NUM_REQ);
    endfunction

    // While locked only the lock holder may win; otherwise first valid at/after rr_q.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        if (locked_q) begin
            found  = req_valid[grant_q];
            winner = grant_q;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && req_valid[rr_index(rr_q, i)]) begin
                    found  = 1'b1;
                    winner = rr_index(rr_q, i);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        data_d   = data_q;
        last_d   = last_q;
        locked_d = locked_q;
        err_d    = err_q;
        timer_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (uart_ready && found) begin
                    state_d = StLaunch;
                    grant_d = winner;
                    data_d  = req_data[32'(winner)*DATA_BITS +: DATA_BITS];
                    last_d  = req_last[winner];
                end else if (LOCK_TIMEOUT != 0 && locked_q && !req_valid[grant_q]) begin
                    if (timer_q == CntW'(LOCK_TIMEOUT - 1)) begin
                        locked_d = 1'b0;
                        err_d    = 1'b1;
                        rr_d     = next_id(grant_q);
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            StLaunch: begin
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                // Timer starts at 0 one cycle after uart_start, so the error lands
                // exactly START_TIMEOUT cycles after the start pulse.
                if (uart_busy) begin
                    state_d = StWaitDone;
                end else if (timer_q == CntW'(START_TIMEOUT - 2)) begin
                    state_d  = StIdle;
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                    rr_d     = next_id(grant_q);
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (uart_ready) begin
                    state_d = StIdle;
                    if (last_q) begin
                        locked_d = 1'b0;
                        rr_d     = next_id(grant_q);
                    end else begin
                        locked_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_q     <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            data_q   <= data_d;
            last_q   <= last_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StLaunch) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    assign uart_start  = (state_q == StLaunch);
    assign uart_data   = data_q;
    assign grant_id    = grant_q;
    assign locked      = locked_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues feed the DUT, a UART model
// answers uart_start, and a monitor checks every launched byte against expectations.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ       = 4;
    localparam int unsigned DATA_BITS     = 8;
    localparam int unsigned START_TIMEOUT = 8;
    localparam int unsigned LOCK_TIMEOUT  = 16;
    localparam int unsigned TX_CYC        = 4;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         uart_start;
    logic [DATA_BITS-1:0]         uart_data;
    logic                         uart_ready;
    logic                         uart_busy;
    logic [1:0]                   grant_id;
    logic                         locked;
    logic                         err_timeout;

    int   checks = 0;
    int   errors = 0;
    int   n_start = 0;
    logic tx_active = 1'b0;
    logic busy_stuck = 1'b0;
    logic ready_block = 1'b0;

    // Expected launches: {locked, id[1:0], data[7:0]}
    logic [10:0] exp_q [$];
    logic [10:0] mon_e;

    logic [8:0] rmem [NUM_REQ][16];
    int         rhead [NUM_REQ] = '{0, 0, 0, 0};
    int         rtail [NUM_REQ] = '{0, 0, 0, 0};

    assign uart_busy  = tx_active;
    assign uart_ready = !tx_active && !ready_block;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_BITS    (DATA_BITS),
        .START_TIMEOUT(START_TIMEOUT),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .uart_start (uart_start),
        .uart_data  (uart_data),
        .uart_ready (uart_ready),
        .uart_busy  (uart_busy),
        .grant_id   (grant_id),
        .locked     (locked),
        .err_timeout(err_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_req(input int id, input logic [7:0] d, input logic l);
        rmem[id][rtail[id]] = {l, d};
        rtail[id]++;
    endtask

    task automatic expect_tx(input int id, input logic [7:0] d, input logic lk);
        exp_q.push_back({lk, 2'(id), d});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        int quiet = 0;
        while (n < budget && !(exp_q.size() == 0 && quiet >= 4)) begin
            @(negedge clk);
            #1;
            n++;
            quiet = (tx_active || uart_start) ? 0 : quiet + 1;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"},  32'(uart_start),  32'd0);
        check({tag, "_ready"},  32'(req_ready),   32'd0);
        check({tag, "_grant"},  32'(grant_id),    32'd0);
        check({tag, "_data"},   32'(uart_data),   32'd0);
        check({tag, "_locked"}, 32'(locked),      32'd0);
        check({tag, "_err"},    32'(err_timeout), 32'd0);
    endtask

    // Requesters: present queue head, advance on the accept pulse.
    initial begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && rhead[i] != rtail[i]) rhead[i]++;
                if (rhead[i] != rtail[i]) begin
                    req_valid[i]                        = 1'b1;
                    req_data[i*DATA_BITS +: DATA_BITS]  = rmem[i][rhead[i]][7:0];
                    req_last[i]                         = rmem[i][rhead[i]][8];
                end else begin
                    req_valid[i]                        = 1'b0;
                    req_data[i*DATA_BITS +: DATA_BITS]  = '0;
                    req_last[i]                         = 1'b0;
                end
            end
        end
    end

    // UART model: busy one cycle after start, for TX_CYC cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && uart_start && !busy_stuck) begin
                @(posedge clk);
                #1 tx_active = 1'b1;
                repeat (TX_CYC) @(posedge clk);
                #1 tx_active = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n && uart_start) begin
            n_start++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: data %0h grant %0d, expected no launch",
                         uart_data, grant_id);
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_data",   32'(uart_data), 32'(mon_e[7:0]));
                check("tx_grant",  32'(grant_id),  32'(mon_e[9:8]));
                check("tx_ready",  32'(req_ready), 32'(4'b0001 << mon_e[9:8]));
                check("tx_locked", 32'(locked),    32'(mon_e[10]));
            end
        end else if (rst_n && req_ready != '0) begin
            checks++;
            errors++;
            $display("FAIL stray_ready: req_ready %0b without uart_start, expected 0", req_ready);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int snap;

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // 1: all four valid, round-robin 0..3, pointer wraps to 0.
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            push_req(i, 8'hA0 + 8'(i), 1'b1);
            expect_tx(i, 8'hA0 + 8'(i), 1'b0);
        end
        wait_drain("drain_rr", 200);
        @(posedge clk);
        push_req(0, 8'hC0, 1'b1);
        push_req(3, 8'hC3, 1'b1);
        expect_tx(0, 8'hC0, 1'b0);
        expect_tx(3, 8'hC3, 1'b0);
        wait_drain("drain_wrap", 200);

        // 2: locked three-byte message from req0 holds off req1.
        @(posedge clk);
        push_req(0, 8'h11, 1'b0);
        push_req(0, 8'h22, 1'b0);
        push_req(0, 8'h33, 1'b1);
        push_req(1, 8'h55, 1'b1);
        expect_tx(0, 8'h11, 1'b0);
        expect_tx(0, 8'h22, 1'b1);
        expect_tx(0, 8'h33, 1'b1);
        expect_tx(1, 8'h55, 1'b0);
        wait_drain("drain_lock", 300);
        check("lock_released", 32'(locked), 32'd0);

        // 3: transmitter never goes busy.
        busy_stuck = 1'b1;
        @(posedge clk);
        push_req(2, 8'h77, 1'b1);
        expect_tx(2, 8'h77, 1'b0);
        n = 0;
        while (!uart_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 32'(uart_start), 32'd1);
        repeat (START_TIMEOUT - 1) @(negedge clk);
        check("start_tmo_early", 32'(err_timeout), 32'd0);
        @(negedge clk);
        check("start_tmo", 32'(err_timeout), 32'd1);
        busy_stuck = 1'b0;
        @(posedge clk);
        push_req(3, 8'h88, 1'b1);
        expect_tx(3, 8'h88, 1'b0);
        wait_drain("drain_after_tmo", 200);
        check("err_sticky", 32'(err_timeout), 32'd1);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset2");
        @(negedge clk);
        rst_n = 1'b1;

        // 4: req2 locks then idles; lock times out and req3 goes.
        @(posedge clk);
        push_req(2, 8'h2A, 1'b0);
        push_req(3, 8'h3B, 1'b1);
        expect_tx(2, 8'h2A, 1'b0);
        expect_tx(3, 8'h3B, 1'b0);
        n = 0;
        while (!locked && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("lock_set", 32'(locked), 32'd1);
        repeat (LOCK_TIMEOUT - 1) @(negedge clk);
        check("lock_hold", 32'(locked), 32'd1);
        check("lock_err_early", 32'(err_timeout), 32'd0);
        @(negedge clk);
        check("lock_drop", 32'(locked), 32'd0);
        check("lock_err", 32'(err_timeout), 32'd1);
        wait_drain("drain_lock_tmo", 200);

        // 5: uart_ready held low blocks any grant.
        ready_block = 1'b1;
        @(posedge clk);
        push_req(1, 8'h5C, 1'b1);
        expect_tx(1, 8'h5C, 1'b0);
        snap = n_start;
        repeat (50) @(negedge clk);
        check("no_start_blocked", 32'(n_start - snap), 32'd0);
        @(posedge clk);
        #1 ready_block = 1'b0;
        @(negedge clk);
        check("start_decision_cycle", 32'(uart_start), 32'd0);
        @(negedge clk);
        check("start_after_ready", 32'(uart_start), 32'd1);
        wait_drain("drain_ready", 200);

        // 6: reset while the locked holder's byte is in flight.
        @(posedge clk);
        push_req(0, 8'h61, 1'b0);
        push_req(0, 8'h62, 1'b0);
        expect_tx(0, 8'h61, 1'b0);
        expect_tx(0, 8'h62, 1'b1);
        n = 0;
        while (!locked && n < 200) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!uart_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("second_start", 32'(uart_start), 32'd1);
        repeat (2) @(negedge clk);
        check("locked_before_rst", 32'(locked), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset3");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        push_req(1, 8'hD1, 1'b1);
        push_req(3, 8'hD3, 1'b1);
        expect_tx(1, 8'hD1, 1'b0);
        expect_tx(3, 8'hD3, 1'b0);
        wait_drain("drain_post_rst", 300);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
